// File: rtl/instr_decode_stage_pkg.sv
// Shared decode types and constants for the instruction decode stage.
// Combinational only; no latency or backpressure.
package instr_decode_stage_pkg;

  localparam int INSTR_LEN = 32;
  localparam int OPC_W     = 11;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_D  = 3'd2,
    FMT_B  = 3'd3,
    FMT_CB = 3'd4,
    FMT_IW = 3'd5
  } fmt_e;

  // Exact-match opcodes; wildcard groups (B/CB/IW/I) live in the classifier casez.
  localparam logic [OPC_W-1:0] OP_STUR   = 11'b11111000000;
  localparam logic [OPC_W-1:0] OP_LDUR   = 11'b11111000010;
  localparam logic [OPC_W-1:0] OP_STURW  = 11'b10111000000;
  localparam logic [OPC_W-1:0] OP_LDURSW = 11'b10111000100;
  localparam logic [OPC_W-1:0] OP_STURH  = 11'b01111000000;
  localparam logic [OPC_W-1:0] OP_LDURH  = 11'b01111000010;
  localparam logic [OPC_W-1:0] OP_STURB  = 11'b00111000000;
  localparam logic [OPC_W-1:0] OP_LDURB  = 11'b00111000010;
  localparam logic [OPC_W-1:0] OP_STXR   = 11'b11001000000;
  localparam logic [OPC_W-1:0] OP_LDXR   = 11'b11001000010;

  localparam logic [OPC_W-1:0] OP_ADD    = 11'b10001011000;
  localparam logic [OPC_W-1:0] OP_ADDS   = 11'b10101011000;
  localparam logic [OPC_W-1:0] OP_SUB    = 11'b11001011000;
  localparam logic [OPC_W-1:0] OP_SUBS   = 11'b11101011000;
  localparam logic [OPC_W-1:0] OP_AND    = 11'b10001010000;
  localparam logic [OPC_W-1:0] OP_ANDS   = 11'b11101010000;
  localparam logic [OPC_W-1:0] OP_ORR    = 11'b10101010000;
  localparam logic [OPC_W-1:0] OP_EOR    = 11'b11001010000;
  localparam logic [OPC_W-1:0] OP_LSL    = 11'b11010011011;
  localparam logic [OPC_W-1:0] OP_LSR    = 11'b11010011010;
  localparam logic [OPC_W-1:0] OP_BR     = 11'b11010110000;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    fmt_e             fmt;
    logic [4:0]       rm;
    logic [4:0]       rn;
    logic [4:0]       rd;
    logic [5:0]       shamt;
    logic [1:0]       hw;
    logic             illegal;
  } dec_hdr_t;

  localparam int HDR_W = $bits(dec_hdr_t);

endpackage

// File: rtl/fifo.sv
// Generic small FIFO (DEPTH 1 or 2) with registered storage and full-based ready.
// Latency: 1 cycle push-to-pop; push_rdy derives from occupancy only, never from pop_rdy.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic             push;
  logic             pop;

  assign push_rdy = (cnt < 2'(DEPTH));
  assign pop_vld  = (cnt != 2'd0);
  assign pop_dat  = mem[rd_ptr];
  assign push     = push_vld & push_rdy;
  assign pop      = pop_vld & pop_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= (DEPTH == 1) ? 1'b0 : ~wr_ptr;
      end
      if (pop) rd_ptr <= (DEPTH == 1) ? 1'b0 : ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/instr_fmt_classify.sv
// LEGv8 format classifier and immediate extender; purely combinational.
// Zero latency, no backpressure; first matching format group wins.
import instr_decode_stage_pkg::*;

module instr_fmt_classify #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [INSTR_LEN-1:0]  instr,
  output fmt_e                  fmt,
  output logic                  illegal,
  output logic [DATA_WIDTH-1:0] imm_ext
);

  logic [OPC_W-1:0] op;
  logic [63:0]      imm_wide;
  logic [63:0]      iw_val;

  assign op      = instr[31:21];
  // hw>=2 pushes the halfword past bit 31, so truncation yields 0 for 32-bit builds.
  assign iw_val  = {48'b0, instr[20:5]} << {instr[22:21], 4'b0000};
  assign imm_ext = imm_wide[DATA_WIDTH-1:0];

  always_comb begin
    fmt      = FMT_R;
    illegal  = 1'b0;
    imm_wide = '0;
    casez (op)
      11'b?00101?????: begin
        fmt      = FMT_B;
        imm_wide = 64'($signed({instr[25:0], 2'b00}));
      end
      11'b1011010????, 11'b01010100???: begin
        fmt      = FMT_CB;
        imm_wide = 64'($signed({instr[23:5], 2'b00}));
      end
      11'b11?100101??: begin
        fmt      = FMT_IW;
        imm_wide = iw_val;
      end
      11'b1001000100?, 11'b1011000100?, 11'b1101000100?, 11'b1111000100?,
      11'b1001001000?, 11'b1111001000?, 11'b1011001000?, 11'b1101001000?: begin
        fmt      = FMT_I;
        imm_wide = {52'b0, instr[21:10]};
      end
      OP_STUR, OP_LDUR, OP_STURW, OP_LDURSW, OP_STURH,
      OP_LDURH, OP_STURB, OP_LDURB, OP_STXR, OP_LDXR: begin
        fmt      = FMT_D;
        imm_wide = 64'($signed(instr[20:12]));
      end
      OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ANDS,
      OP_ORR, OP_EOR, OP_LSL, OP_LSR, OP_BR: begin
        fmt      = FMT_R;
        imm_wide = {58'b0, instr[15:10]};
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered LEGv8 decode stage; 1-cycle latency, full throughput; optional INSTR_DECODE_STATS_EN counters.
// Backpressure: SKID_DEPTH-entry output buffer; in_ready depends only on occupancy.
import instr_decode_stage_pkg::*;

module instr_decode_stage #(
  parameter int INSTR_LEN  = 32,
  parameter int DATA_WIDTH = 64,
  parameter int SKID_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [INSTR_LEN-1:0]  in_instr,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [10:0]           out_opcode,
  output logic [2:0]            out_fmt,
  output logic [4:0]            out_rm,
  output logic [4:0]            out_rn,
  output logic [4:0]            out_rd,
  output logic [5:0]            out_shamt,
  output logic [1:0]            out_hw,
  output logic [DATA_WIDTH-1:0] out_imm_ext,
  output logic                  out_illegal
`ifdef INSTR_DECODE_STATS_EN
  ,
  output logic [31:0]           stat_decoded,
  output logic [31:0]           stat_illegal
`endif
);

  localparam int BUF_W = HDR_W + DATA_WIDTH;

  fmt_e                  c_fmt;
  logic                  c_illegal;
  logic [DATA_WIDTH-1:0] c_imm;
  dec_hdr_t              c_hdr;
  dec_hdr_t              q_hdr;
  logic [BUF_W-1:0]      pop_dat;

  instr_fmt_classify #(.DATA_WIDTH(DATA_WIDTH)) u_classify (
    .instr   (in_instr),
    .fmt     (c_fmt),
    .illegal (c_illegal),
    .imm_ext (c_imm)
  );

  always_comb begin
    c_hdr         = '0;
    c_hdr.opcode  = in_instr[31:21];
    c_hdr.fmt     = c_fmt;
    c_hdr.rm      = in_instr[20:16];
    c_hdr.rn      = in_instr[9:5];
    c_hdr.rd      = in_instr[4:0];
    c_hdr.shamt   = in_instr[15:10];
    c_hdr.hw      = in_instr[22:21];
    c_hdr.illegal = c_illegal;
  end

  fifo #(.WIDTH(BUF_W), .DEPTH(SKID_DEPTH)) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat ({c_hdr, c_imm}),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (pop_dat)
  );

  assign q_hdr       = pop_dat[BUF_W-1 -: HDR_W];
  assign out_imm_ext = pop_dat[DATA_WIDTH-1:0];
  assign out_opcode  = q_hdr.opcode;
  assign out_fmt     = q_hdr.fmt;
  assign out_rm      = q_hdr.rm;
  assign out_rn      = q_hdr.rn;
  assign out_rd      = q_hdr.rd;
  assign out_shamt   = q_hdr.shamt;
  assign out_hw      = q_hdr.hw;
  assign out_illegal = q_hdr.illegal;

`ifdef INSTR_DECODE_STATS_EN
  logic out_fire;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_decoded <= '0;
      stat_illegal <= '0;
    end else if (out_fire) begin
      if (stat_decoded != '1) stat_decoded <= stat_decoded + 32'd1;
      if (q_hdr.illegal && stat_illegal != '1) stat_illegal <= stat_illegal + 32'd1;
    end
  end
`else
`endif

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Registered, handshaked successor to the combinational field splitter.
- Accepts one LEGv8 instruction word per cycle and classifies its format (R, I, D, B, CB, IW).
- Extracts all fields, builds a sign- or zero-extended immediate of parametrised width and flags unrecognised opcodes.
- Sits between instruction fetch and register read; a 2-entry output skid buffer absorbs downstream stalls without bubbles.

Parameters:
- INSTR_LEN, 32, instruction word width; only 32 is legal.
- DATA_WIDTH, 64, width of imm_ext; legal values are 32 and 64.
- SKID_DEPTH, 2, output buffer entries; legal values are 1 and 2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction present.
- in_instr  in  INSTR_LEN  instruction word.
- in_ready  out  1  stage can accept.
- out_valid  out  1  decoded entry present.
- out_ready  in  1  consumer accepts.
- out_opcode  out  11  instr[31:21].
- out_fmt  out  3  format code: R=0, I=1, D=2, B=3, CB=4, IW=5.
- out_rm  out  5  instr[20:16].
- out_rn  out  5  instr[9:5].
- out_rd  out  5  instr[4:0]; Rt for D/CB.
- out_shamt  out  6  instr[15:10].
- out_hw  out  2  instr[22:21].
- out_imm_ext  out  DATA_WIDTH  extended immediate.
- out_illegal  out  1  opcode matched no format.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (reset_n). Asserting it empties the buffer immediately. While reset_n is low and after release: out_valid=0, all out_* data=0, in_ready=1. Reset mid-stall discards all buffered entries.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = (count < SKID_DEPTH), registered-equivalent. It must not depend combinationally on out_ready.
  - out_* data is stable while out_valid && !out_ready.
- Latency: an instruction accepted at edge N appears at out_valid after edge N+1 when the buffer was empty. Throughput is 1 instruction/cycle while out_ready=1.
- Simultaneous push and pop with count=SKID_DEPTH is not possible because in_ready=0. A simultaneous push and pop at any other count leaves count unchanged and preserves order.
- Format priority, first match wins:
  - B: opcode[10:5] in {000101, 100101}.
  - CB: opcode[10:3] in {10110100, 10110101, 01010100}.
  - IW: opcode[10:2] in {110100101, 111100101}.
  - I: opcode[10:1] in {1001000100, 1011000100, 1101000100, 1111000100, 1001001000, 1111001000, 1011001000, 1101001000}.
  - D: opcode in {11111000010, 11111000000, 10111000100, 10111000000, 01111000010, 01111000000, 00111000010, 00111000000, 11001000010, 11001000000}.
  - R: opcode in {ADD 10001011000, ADDS 10101011000, SUB 11001011000, SUBS 11101011000, AND 10001010000, ANDS 11101010000, ORR 10101010000, EOR 11001010000, LSL 11010011011, LSR 11010011010, BR 11010110000}.
  - No match: fmt=R, illegal=1, imm_ext=0.
- imm_ext by format:
  - I: zero-extend instr[21:10].
  - D: sign-extend instr[20:12].
  - B: sign-extend {instr[25:0],2'b00}.
  - CB: sign-extend {instr[23:5],2'b00}.
  - IW: zero-extend instr[20:5] shifted left by 16*hw. When DATA_WIDTH=32 and hw>=2, imm_ext=0.
  - R: zero-extend shamt.
- All extension is computed before the buffer; the output is purely registered.

Optional Feature:
- Macro: INSTR_DECODE_STATS_EN.
- When defined, adds outputs stat_decoded (32 bits) and stat_illegal (32 bits).
  - stat_decoded increments on each output transfer.
  - stat_illegal increments on each output transfer with out_illegal=1.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/header (constants.vh):
  - INSTR_LEN.
  - Format code localparams FMT_R through FMT_IW.
  - Opcode match constants.
  - Decoded-bundle width macro.
- Sub-module instr_fmt_classify: combinational; takes the instruction and returns fmt, illegal and imm_ext.
- The top level holds the skid buffer and handshake.

Test Plan:
- Reset then instr 0x91000421 (ADDI X1,X1,#1) with out_ready=1 → 1 cycle later out_fmt=1, rd=1, rn=1, imm_ext=1, illegal=0.
- B with imm26=0x3FFFFFF → fmt=3, imm_ext=0xFFFF_FFFF_FFFF_FFFC. LDUR with addr 0x1FF → fmt=2, imm_ext=0xFFFF_FFFF_FFFF_FFFF.
- MOVK imm16=0xBEEF, hw=3, DATA_WIDTH=64 → imm_ext=0xBEEF_0000_0000_0000. The same instruction with DATA_WIDTH=32 → imm_ext=0.
- Stream 6 instructions with out_ready held 0 → in_ready drops after 2 accepts. Releasing out_ready delivers all 6 in order with no loss or duplication.
- Instruction 0x00000000 → illegal=1, fmt=0. With INSTR_DECODE_STATS_EN, after 3 illegal and 2 legal transfers: stat_illegal=3, stat_decoded=5.
- Assert reset_n low with 2 entries buffered → out_valid=0 immediately, in_ready=1. After release, no stale entry appears.
